// File: rtl/full_adder_cell.sv
// full_adder_cell: WIDTH-bit ripple-carry adder with a registered, valid-tagged copy.
// Ports: clk, rst_n (sync, active-low), x, y, c_in, in_valid -> z, c_out, z_q, c_out_q, out_valid.
module full_adder_cell #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] z,
    output logic             c_out,
    output logic [WIDTH-1:0] z_q,
    output logic             c_out_q,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = c_in;

    // One full-adder cell per bit; carry ripples LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]     = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i])
                          | (x[i] & carry[i])
                          | (y[i] & carry[i]);
    end

    assign z     = sum;
    assign c_out = carry[WIDTH];

    // Result registers hold when idle; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q       <= '0;
            c_out_q   <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            z_q       <= sum;
            c_out_q   <= carry[WIDTH];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_full_adder_cell.sv
// tb_full_adder_cell: table-driven and scoreboard checks of full_adder_cell.
// Ports: none; instantiates a 1-bit and a 64-bit cell sharing clk and rst_n.
module tb_full_adder_cell;

    logic clk;
    logic rst_n;

    logic x1, y1, c1, v1;
    logic z1, co1, zq1, coq1, ov1;

    logic [63:0] x64, y64, z64, zq64;
    logic        c64, v64, co64, coq64, ov64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic x;
        logic y;
        logic c;
        logic z;
        logic co;
    } vec_t;

    vec_t       tt[8];
    logic [1:0] q1[$];
    logic [64:0] q64[$];

    full_adder_cell #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .x(x1), .y(y1), .c_in(c1), .in_valid(v1),
        .z(z1), .c_out(co1),
        .z_q(zq1), .c_out_q(coq1), .out_valid(ov1)
    );

    full_adder_cell #(.WIDTH(64)) u64 (
        .clk(clk), .rst_n(rst_n),
        .x(x64), .y(y64), .c_in(c64), .in_valid(v64),
        .z(z64), .c_out(co64),
        .z_q(zq64), .c_out_q(coq64), .out_valid(ov64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act,
                       input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pop1(input string name);
        logic [1:0] e;
        if (q1.size() == 0) begin
            chk({name, "_empty"}, 65'd1, 65'd0);
        end else begin
            e = q1.pop_front();
            chk(name, {62'd0, ov1, coq1, zq1}, {62'd0, 1'b1, e});
        end
    endtask

    task automatic pop64(input string name);
        logic [64:0] e;
        if (q64.size() == 0) begin
            chk({name, "_empty"}, 65'd1, 65'd0);
        end else begin
            e = q64.pop_front();
            chk(name, {coq64, zq64}, e);
            chk({name, "_ov"}, {64'd0, ov64}, 65'd1);
        end
    endtask

    initial begin
        logic [64:0] s;
        for (int i = 0; i < 8; i++) begin
            tt[i].x  = i[2];
            tt[i].y  = i[1];
            tt[i].c  = i[0];
            tt[i].z  = i[2] ^ i[1] ^ i[0];
            tt[i].co = (i[2] & i[1]) | (i[2] & i[0]) | (i[1] & i[0]);
        end

        // Reset held two edges while valid inputs are presented.
        rst_n = 1'b0;
        x1 = 1'b1; y1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
        x64 = '0; y64 = '0; c64 = 1'b0; v64 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w1", {62'd0, ov1, coq1, zq1}, 65'd0);
        chk("rst_w64", {ov64, coq64, zq64[62:0]}, 65'd0);
        chk("rst_comb", {63'd0, co1, z1}, 65'd3);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release", {62'd0, ov1, coq1, zq1}, 65'd7);

        // Exhaustive 1-bit truth table through the scoreboard.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            x1 = tt[i].x; y1 = tt[i].y; c1 = tt[i].c; v1 = 1'b1;
            q1.push_back({tt[i].co, tt[i].z});
            #1;
            chk($sformatf("tt_comb%0d", i), {63'd0, co1, z1},
                {63'd0, tt[i].co, tt[i].z});
            @(posedge clk);
            #1;
            pop1($sformatf("tt_reg%0d", i));
        end

        // Inputs change between edges; outputs follow with no clock.
        @(negedge clk);
        v1 = 1'b0;
        x1 = 1'b1; y1 = 1'b1; c1 = 1'b0;
        #1;
        chk("settle_a", {63'd0, co1, z1}, 65'd2);
        #1;
        x1 = 1'b0; y1 = 1'b0; c1 = 1'b1;
        #1;
        chk("settle_b", {63'd0, co1, z1}, 65'd1);

        // Capture then hold with in_valid low.
        @(negedge clk);
        x1 = 1'b1; y1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
        @(negedge clk);
        x1 = 1'b1; y1 = 1'b1; c1 = 1'b1; v1 = 1'b0;
        @(posedge clk);
        #1;
        chk("hold", {62'd0, ov1, coq1, zq1}, 65'd1);
        @(posedge clk);
        #1;
        chk("hold2", {62'd0, ov1, coq1, zq1}, 65'd1);

        // Reset mid-stream discards the held result.
        @(negedge clk);
        rst_n = 1'b0; v1 = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst", {62'd0, ov1, coq1, zq1}, 65'd0);
        @(negedge clk);
        rst_n = 1'b1; v1 = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_idle", {62'd0, ov1, coq1, zq1}, 65'd0);

        // 64-bit carry chain corners.
        @(negedge clk);
        x64 = 64'hFFFF_FFFF_FFFF_FFFF; y64 = '0; c64 = 1'b1;
        #1;
        chk("chain_ripple", {co64, z64}, {1'b1, 64'd0});
        x64 = 64'h8000_0000_0000_0000;
        y64 = 64'h8000_0000_0000_0000; c64 = 1'b0;
        #1;
        chk("chain_msb", {co64, z64}, {1'b1, 64'd0});
        x64 = 64'hFFFF_FFFF_FFFF_FFFF;
        y64 = 64'hFFFF_FFFF_FFFF_FFFF; c64 = 1'b1;
        #1;
        chk("chain_max", {co64, z64}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});

        // Random back-to-back valids; z_q must trail z by one cycle.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            x64 = {$urandom, $urandom};
            y64 = {$urandom, $urandom};
            c64 = $urandom_range(0, 1) == 1;
            v64 = 1'b1;
            s = {1'b0, x64} + {1'b0, y64} + {64'd0, c64};
            q64.push_back(s);
            #1;
            chk("rnd_comb", {co64, z64}, s);
            @(posedge clk);
            #1;
            pop64("rnd_reg");
        end

        // Idle cycle drops valid and keeps the last result.
        @(negedge clk);
        v64 = 1'b0;
        x64 = '0; y64 = '0; c64 = 1'b0;
        @(posedge clk);
        #1;
        chk("idle64_ov", {64'd0, ov64}, 65'd0);
        chk("idle64_hold", {coq64, zq64}, s);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_adder_cell.md
# full_adder_cell

Full-adder cell for the ALU-64 datapath: adds operands `x`, `y` and carry-in `c_in`, producing sum `z` and carry-out `c_out`. The arithmetic path is purely combinational, so the result is available in the same cycle. A registered copy of the result, with a valid flag, lets the cell feed pipelined ALU stages. With the default `WIDTH = 1` it is the 1-bit building block that is chained into the ripple/carry structures of the 64-bit adder.

## Interface
- `WIDTH`, default 1: operand width in bits. Legal range is 1..64. Bit cells ripple internally from LSB to MSB.
- `clk`  in  1  single clock; all registers update on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `x`  in  WIDTH  operand A.
- `y`  in  WIDTH  operand B.
- `c_in`  in  1  carry into bit 0.
- `in_valid`  in  1  qualifies `x`/`y`/`c_in` for capture into the output register.
- `z`  out  WIDTH  combinational sum.
- `c_out`  out  1  combinational carry out of the MSB.
- `z_q`  out  WIDTH  registered sum.
- `c_out_q`  out  1  registered carry.
- `out_valid`  out  1  `z_q`/`c_out_q` hold a captured result.

## Operation
- Combinational path, per bit i:
  - s_i = x_i ^ y_i ^ c_i
  - c_{i+1} = (x_i & y_i) | (x_i & c_i) | (y_i & c_i)
  - c_0 = `c_in`; `c_out` = c_WIDTH.
- Equivalently, {`c_out`, `z`} = `x` + `y` + `c_in`, computed exactly in WIDTH+1 bits with no truncation of the carry.
- Combinational outputs `z` and `c_out` do not depend on `clk`, `rst_n` or `in_valid`.
- Register stage, on each rising `clk` edge:
  - `rst_n` = 0: `z_q` ← 0, `c_out_q` ← 0, `out_valid` ← 0.
  - `rst_n` = 1 and `in_valid` = 1: `z_q` ← `z`, `c_out_q` ← `c_out`, `out_valid` ← 1.
  - `rst_n` = 1 and `in_valid` = 0: `z_q` and `c_out_q` hold; `out_valid` ← 0.
- No backpressure. A new result may be captured every cycle.
- Any X/Z on an input propagates to the outputs. The cell does not mask it.

## Timing
- `z`/`c_out` latency: 0 cycles, purely combinational. Critical path is the WIDTH-bit carry ripple from `c_in` to `c_out`.
- `z_q`/`c_out_q`/`out_valid` latency: 1 cycle after the edge that samples `in_valid` = 1.
- Reset values: `z_q` = 0, `c_out_q` = 0, `out_valid` = 0. `z` and `c_out` have no reset value because they follow the inputs.
- Reset and `in_valid` asserted on the same edge: reset wins and nothing is captured.
- Reset mid-stream: the registered result is discarded. The first valid result appears 1 cycle after the first `in_valid` edge following reset release.
- Back-to-back valids: each cycle's inputs appear in `z_q` on the following cycle, with no bubbles.

## Test plan
- WIDTH = 1 exhaustive truth table. Step {x, y, c_in} through 0..7, one vector every 10 time units. Required {z, c_out}: 000→(0,0), 001→(1,0), 010→(1,0), 011→(0,1), 100→(1,0), 101→(0,1), 110→(0,1), 111→(1,1).
- Combinational settling: change inputs between clock edges; `z`/`c_out` must update within the same time step, with no `clk` needed.
- Reset: hold `rst_n` = 0 for 2 edges with `in_valid` = 1 and x=y=c_in=1. Required: `z_q` = 0, `c_out_q` = 0, `out_valid` = 0. Release reset; one edge later `z_q` = 1, `c_out_q` = 1, `out_valid` = 1.
- Register hold: capture x=1, y=0, c_in=0, then drive `in_valid` = 0 with x=y=c_in=1. Required: `z_q` stays 1, `c_out_q` stays 0, `out_valid` = 0.
- WIDTH = 64 carry chain: x = 0xFFFF_FFFF_FFFF_FFFF, y = 0, c_in = 1 → `z` = 0, `c_out` = 1. x = y = 0x8000_0000_0000_0000, c_in = 0 → `z` = 0, `c_out` = 1.
- WIDTH = 64 random: 1000 random x/y/c_in vectors with `in_valid` = 1 every cycle. Required: {`c_out`, `z`} equals the 65-bit sum, and `z_q` equals the previous cycle's `z`.
